dout_writer: RTL and testbench



---
 rtl/dout_pkg.sv | 26 ++
 rtl/dout_dclk_gen.sv | 40 ++++
 rtl/dout_writer.sv | 166 ++++++++++++++++
 tb/tb_dout_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dout_pkg.sv
// Shared constants, FSM state type and word packing for the dout transmitter.
// Word layout on the wire, MSB first: {err, 4'b0000, ch_id[2:0], data[23:0]}.
package dout_pkg;

  localparam int unsigned N_LANES     = 4;
  localparam int unsigned N_CH        = 8;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned HEADER_BITS = 8;
  localparam int unsigned PAYLOAD_BITS = WORD_BITS - HEADER_BITS;
  // Each lane carries two consecutive channel words per frame.
  localparam int unsigned CH_PER_LANE = N_CH / N_LANES;
  localparam int unsigned LANE_BITS   = WORD_BITS * CH_PER_LANE;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } dout_state_e;

  function automatic logic [WORD_BITS-1:0] make_word(input logic                    err,
                                                     input logic [2:0]              ch_id,
                                                     input logic [PAYLOAD_BITS-1:0] data);
    return {err, 4'b0000, ch_id, data};
  endfunction

endpackage

// File: rtl/dout_dclk_gen.sv
// Free-running serial clock divider for the dout transmitter.
//   clk_i, reset_ni : system clock, asynchronous active-low reset
//   dclk_o          : serial clock, toggles every DCLK_DIV cycles, first edge after reset is high
//   rise_o, fall_o  : one-cycle strobes, high in the cycle whose closing clk_i edge makes dclk_o
//                     rise / fall, so registers updated on fall_o change together with dclk_o
module dout_dclk_gen #(
  parameter int unsigned DCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  output logic dclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (DCLK_DIV > 1) ? $clog2(DCLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            dclk_q;
  logic            wrap;

  assign wrap   = (cnt_q == CntW'(DCLK_DIV - 1));
  assign rise_o = wrap && !dclk_q;
  assign fall_o = wrap && dclk_q;
  assign dclk_o = dclk_q;

  // Counter resets to its terminal value so the first edge after release raises dclk.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= CntW'(DCLK_DIV - 1);
      dclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      dclk_q <= ~dclk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dout_writer.sv
// Transmit side of the 4-lane, 8-channel ADC dout interface.
//   clk_i, reset_ni   : system clock, asynchronous active-low reset
//   enable_i          : frame generation enable
//   ch1_i..ch8_i      : signed channel samples, snapshotted at frame start
//   err_i             : error flag copied into every word header
//   drdy_o            : high for one dclk period at frame start
//   dclk_o            : serial clock; data changes on its falling edge
//   dout0_o..dout3_o  : serial lanes, lane n carries ch(2n+1) then ch(2n+2), MSB first
//   tick_o            : one-cycle pulse at snapshot
//   busy_o            : high while a frame is in flight
module dout_writer
  import dout_pkg::*;
#(
  parameter int unsigned DCLK_DIV     = 4,
  parameter int unsigned FRAME_PERIOD = 2000,
  parameter int unsigned DATA_BITS    = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 enable_i,
  input  logic [DATA_BITS-1:0] ch1_i,
  input  logic [DATA_BITS-1:0] ch2_i,
  input  logic [DATA_BITS-1:0] ch3_i,
  input  logic [DATA_BITS-1:0] ch4_i,
  input  logic [DATA_BITS-1:0] ch5_i,
  input  logic [DATA_BITS-1:0] ch6_i,
  input  logic [DATA_BITS-1:0] ch7_i,
  input  logic [DATA_BITS-1:0] ch8_i,
  input  logic                 err_i,
  output logic                 drdy_o,
  output logic                 dclk_o,
  output logic                 dout0_o,
  output logic                 dout1_o,
  output logic                 dout2_o,
  output logic                 dout3_o,
  output logic                 tick_o,
  output logic                 busy_o
);

  localparam int unsigned TimerW  = $clog2(FRAME_PERIOD);
  localparam int unsigned BitCntW = $clog2(LANE_BITS);

  if (DCLK_DIV < 1) begin : gen_bad_div
    $error("DCLK_DIV must be at least 1");
  end
  if ((FRAME_PERIOD % (2 * DCLK_DIV)) != 0 || FRAME_PERIOD < 66 * 2 * DCLK_DIV) begin : gen_bad_period
    $error("FRAME_PERIOD must be a multiple of 2*DCLK_DIV and at least 66 dclk periods");
  end
  if (DATA_BITS != PAYLOAD_BITS) begin : gen_bad_data
    $error("DATA_BITS must equal the word payload width");
  end

  logic rise, fall;

  dout_dclk_gen #(
    .DCLK_DIV(DCLK_DIV)
  ) u_dclk_gen (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .dclk_o  (dclk_o),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // Frame timer. run_q marks that the timer has locked onto a falling edge; until then the
  // first falling edge after enable starts a frame. FRAME_PERIOD is a whole number of dclk
  // periods, so every later wrap to 0 also lands on a falling edge.
  logic [TimerW-1:0] timer_q;
  logic              run_q;
  logic              frame_start;

  assign frame_start = enable_i && fall && (!run_q || (timer_q == '0));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      timer_q <= '0;
      run_q   <= 1'b0;
    end else if (!enable_i) begin
      timer_q <= '0;
      run_q   <= 1'b0;
    end else if (!run_q) begin
      if (fall) begin
        run_q   <= 1'b1;
        timer_q <= TimerW'(1);
      end
    end else if (timer_q == TimerW'(FRAME_PERIOD - 1)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  logic [DATA_BITS-1:0] ch [N_CH];
  assign ch[0] = ch1_i;
  assign ch[1] = ch2_i;
  assign ch[2] = ch3_i;
  assign ch[3] = ch4_i;
  assign ch[4] = ch5_i;
  assign ch[5] = ch6_i;
  assign ch[6] = ch7_i;
  assign ch[7] = ch8_i;

  logic [LANE_BITS-1:0] lane_load [N_LANES];

  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      lane_load[l] = {make_word(err_i, 3'(2 * l), ch[2 * l]),
                      make_word(err_i, 3'(2 * l + 1), ch[2 * l + 1])};
    end
  end

  dout_state_e          state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [LANE_BITS-1:0] lane_q [N_LANES];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      drdy_o    <= 1'b0;
      tick_o    <= 1'b0;
      busy_o    <= 1'b0;
      for (int l = 0; l < N_LANES; l++) lane_q[l] <= '0;
    end else begin
      tick_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q   <= StShift;
            bit_cnt_q <= BitCntW'(LANE_BITS - 1);
            drdy_o    <= 1'b1;
            tick_o    <= 1'b1;
            busy_o    <= 1'b1;
            for (int l = 0; l < N_LANES; l++) lane_q[l] <= lane_load[l];
          end
        end
        StShift: begin
          if (fall) begin
            drdy_o <= 1'b0;
            if (bit_cnt_q == '0) begin
              // Bit 0 has now been held for a full dclk period.
              state_q <= StDone;
              busy_o  <= 1'b0;
              for (int l = 0; l < N_LANES; l++) lane_q[l] <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
              for (int l = 0; l < N_LANES; l++) lane_q[l] <= {lane_q[l][LANE_BITS-2:0], 1'b0};
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout0_o = lane_q[0][LANE_BITS-1];
  assign dout1_o = lane_q[1][LANE_BITS-1];
  assign dout2_o = lane_q[2][LANE_BITS-1];
  assign dout3_o = lane_q[3][LANE_BITS-1];

  // A start outside idle is dropped by the FSM; parameter checks make it unreachable.
  assert property (@(posedge clk_i) disable iff (!reset_ni) frame_start |-> (state_q == StIdle));
  assert property (@(posedge clk_i) disable iff (!reset_ni) !(rise && fall));

endmodule

// File: tb/tb_dout_writer.sv
module tb_dout_writer;

  localparam int unsigned DclkDiv     = 2;
  localparam int unsigned FramePeriod = 400;
  localparam int unsigned NFrames     = 4;

  typedef logic [3:0][63:0] frame_t;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        err_i = 1'b0;
  logic [23:0] ch [8];
  logic        drdy_o, dclk_o, dout0_o, dout1_o, dout2_o, dout3_o, tick_o, busy_o;
  logic [3:0]  lanes;

  assign lanes = {dout3_o, dout2_o, dout1_o, dout0_o};

  always #5 clk_i = ~clk_i;

  dout_writer #(
    .DCLK_DIV    (DclkDiv),
    .FRAME_PERIOD(FramePeriod),
    .DATA_BITS   (24)
  ) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .enable_i(enable_i),
    .ch1_i   (ch[0]),
    .ch2_i   (ch[1]),
    .ch3_i   (ch[2]),
    .ch4_i   (ch[3]),
    .ch5_i   (ch[4]),
    .ch6_i   (ch[5]),
    .ch7_i   (ch[6]),
    .ch8_i   (ch[7]),
    .err_i   (err_i),
    .drdy_o  (drdy_o),
    .dclk_o  (dclk_o),
    .dout0_o (dout0_o),
    .dout1_o (dout1_o),
    .dout2_o (dout2_o),
    .dout3_o (dout3_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver-style monitor: samples lanes on dclk rising edges after each drdy rise.
  int     rise_q[$], tick_q[$], drdy_len_q[$], busy_len_q[$];
  frame_t frame_q[$];
  logic   dclk_p = 1'b0, drdy_p = 1'b0, busy_p = 1'b0, cap_on = 1'b0;
  int     cap_n = 0, drdy_t0 = 0, busy_t0 = 0;
  frame_t cap;

  always @(negedge clk_i) begin
    if (!reset_ni) begin
      cap_on = 1'b0;
      dclk_p = 1'b0;
      drdy_p = 1'b0;
      busy_p = 1'b0;
    end else begin
      if (drdy_o && !drdy_p) begin
        rise_q.push_back(cyc);
        drdy_t0 = cyc;
        cap_on  = 1'b1;
        cap_n   = 0;
        cap     = '0;
      end
      if (!drdy_o && drdy_p) drdy_len_q.push_back(cyc - drdy_t0);
      if (tick_o) tick_q.push_back(cyc);
      if (busy_o && !busy_p) busy_t0 = cyc;
      if (!busy_o && busy_p) busy_len_q.push_back(cyc - busy_t0);
      if (cap_on && dclk_o && !dclk_p) begin
        for (int l = 0; l < 4; l++) cap[l] = {cap[l][62:0], lanes[l]};
        cap_n++;
        if (cap_n == 64) begin
          frame_q.push_back(cap);
          cap_on = 1'b0;
        end
      end
      dclk_p = dclk_o;
      drdy_p = drdy_o;
      busy_p = busy_o;
    end
  end

  // Reference: word value as header fields weighted by bit position plus the raw payload.
  function automatic logic [31:0] ref_word(input logic err, input int ch_num, input logic [23:0] d);
    return 32'(err) * 32'h8000_0000 + 32'(ch_num - 1) * 32'h0100_0000 + 32'(d);
  endfunction

  function automatic frame_t ref_frame();
    frame_t f;
    for (int l = 0; l < 4; l++) begin
      f[l] = {ref_word(err_i, 2 * l + 1, ch[2 * l]), ref_word(err_i, 2 * l + 2, ch[2 * l + 1])};
    end
    return f;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 8; i++) ch[i] = 24'($urandom);
    err_i = 1'($urandom);
  endtask

  task automatic wait_rises(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (rise_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic measure_dclk(output int p);
    logic prev;
    int   t0, n;
    p    = -1;
    n    = 0;
    t0   = 0;
    prev = dclk_o;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (dclk_o && !prev) begin
        if (n == 0) t0 = cyc;
        else begin
          p = cyc - t0;
          break;
        end
        n++;
      end
      prev = dclk_o;
    end
  endtask

  frame_t exp_q[$];
  int     p;
  logic   ok;
  int     sv_obs, sv_exp;

  initial begin
    for (int i = 0; i < 8; i++) ch[i] = '0;

    // Reset state and free-running dclk with the writer disabled.
    repeat (5) @(negedge clk_i);
    #1 check("reset_outputs", 64'({drdy_o, dclk_o, lanes, tick_o, busy_o}), 64'(0));
    @(negedge clk_i);
    reset_ni = 1'b1;
    measure_dclk(p);
    check("dclk_period_boot", 64'(p), 64'(4));
    repeat (40) @(negedge clk_i);
    check("no_drdy_disabled", 64'(rise_q.size()), 64'(0));

    // Start a frame, then hit reset in the middle of shifting.
    scramble();
    enable_i = 1'b1;
    wait_rises(1, ok);
    check("abort_frame_start", 64'(ok), 64'(1));
    repeat (60) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      if (dclk_o) break;
      @(negedge clk_i);
    end
    check("busy_before_reset", 64'(busy_o), 64'(1));
    reset_ni = 1'b0;
    enable_i = 1'b0;
    #1 check("reset_midframe_outputs", 64'({drdy_o, dclk_o, lanes, tick_o, busy_o}), 64'(0));
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    measure_dclk(p);
    check("dclk_period_after_reset", 64'(p), 64'(4));
    repeat (100) @(negedge clk_i);
    check("no_drdy_after_reset", 64'(rise_q.size()), 64'(1));
    check("aborted_frame_not_captured", 64'(frame_q.size()), 64'(0));
    rise_q.delete();
    tick_q.delete();
    drdy_len_q.delete();
    busy_len_q.delete();

    // Back-to-back frames; inputs scrambled mid-frame; enable dropped inside the last one.
    for (int k = 0; k < NFrames; k++) begin
      scramble();
      if (k == 0) begin
        ch[0] = 24'h123456;
        ch[1] = 24'hABCDEF;
        err_i = 1'b0;
      end else if (k == 1) begin
        ch[2] = 24'hFFFFFF;
        err_i = 1'b1;
      end
      exp_q.push_back(ref_frame());
      enable_i = 1'b1;
      wait_rises(k + 1, ok);
      check($sformatf("frame%0d_start", k), 64'(ok), 64'(1));
      if (k == NFrames - 1) begin
        repeat (100) @(negedge clk_i);
        enable_i = 1'b0;
        scramble();
      end else begin
        repeat (20) @(negedge clk_i);
        scramble();
        repeat (280) @(negedge clk_i);
      end
    end
    repeat (600) @(negedge clk_i);

    check("drdy_count", 64'(rise_q.size()), 64'(NFrames));
    check("frame_count", 64'(frame_q.size()), 64'(NFrames));
    check("tick_count", 64'(tick_q.size()), 64'(NFrames));
    check("busy_count", 64'(busy_len_q.size()), 64'(NFrames));
    check("drdy_len_count", 64'(drdy_len_q.size()), 64'(NFrames));

    if (frame_q.size() >= 2) begin
      check("f0_dout0_word0", 64'(frame_q[0][0][63:32]), 64'h0012_3456);
      check("f0_dout0_word1", 64'(frame_q[0][0][31:0]), 64'h01AB_CDEF);
      check("f1_dout1_word0", 64'(frame_q[1][1][63:32]), 64'h82FF_FFFF);
    end

    for (int k = 0; k < NFrames; k++) begin
      if (k < frame_q.size()) begin
        for (int l = 0; l < 4; l++) begin
          check($sformatf("f%0d_lane%0d", k, l), frame_q[k][l], exp_q[k][l]);
          for (int w = 0; w < 2; w++) begin
            // Loopback view: sign-extended payload must equal the sample that was driven.
            logic [31:0] rx, ex;
            rx     = (w == 0) ? frame_q[k][l][63:32] : frame_q[k][l][31:0];
            ex     = (w == 0) ? exp_q[k][l][63:32] : exp_q[k][l][31:0];
            sv_obs = int'($signed(rx[23:0]));
            sv_exp = int'($signed(ex[23:0]));
            check($sformatf("f%0d_ch%0d_value", k, 2 * l + w + 1), 64'(sv_obs), 64'(sv_exp));
          end
        end
      end
      if (k < drdy_len_q.size()) check($sformatf("f%0d_drdy_len", k), 64'(drdy_len_q[k]), 64'(4));
      if (k < busy_len_q.size()) check($sformatf("f%0d_busy_len", k), 64'(busy_len_q[k]), 64'(256));
      if (k < tick_q.size() && k < rise_q.size())
        check($sformatf("f%0d_tick_at_drdy", k), 64'(tick_q[k]), 64'(rise_q[k]));
      if (k > 0 && k < rise_q.size())
        check($sformatf("f%0d_spacing", k), 64'(rise_q[k] - rise_q[k-1]), 64'(FramePeriod));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
